branch_rs_multi: RTL and testbench

Parametrised, multi-entry branch reservation station for the Tomasulo core; the successor to the single-entry, BGE-only branch RS. Holds up to DEPTH in-flight conditional branches issued from the instruction CDB. Each entry resolves its two source operands by snooping the data CDB, then evaluates one of several compare modes. Entries are dispatched oldest-ready-first to a one-deep result register that drives this FU's slot on the result buses with a valid/ready handshake.

---
 rtl/branch_rs_multi_if.sv | 36 +++
 rtl/branch_rs_multi.sv | 194 +++++++++++++++++++
 tb/tb_branch_rs_multi.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_rs_multi_if.sv
// Bundle of issue, data-CDB and result handshake signals for branch_rs_multi.
// master = issuing/consuming side, slave = the reservation station.
interface branch_rs_multi_if #(
  parameter int WORD_SIZE = 32,
  parameter int RB_INDEX  = 4,
  parameter int RB_SIZE   = 16
);
  logic                          flush;
  logic                          issue_valid;
  logic                          issue_ready;
  logic [2:0]                    issue_op;
  logic [RB_INDEX-1:0]           issue_dest;
  logic [WORD_SIZE-1:0]          issue_vj;
  logic [WORD_SIZE-1:0]          issue_vk;
  logic [RB_INDEX-1:0]           issue_qj;
  logic [RB_INDEX-1:0]           issue_qk;
  logic [WORD_SIZE*RB_SIZE-1:0]  cdb_data;
  logic [RB_SIZE-1:0]            cdb_valid;
  logic                          out_valid;
  logic                          out_ready;
  logic [RB_INDEX-1:0]           out_dest;
  logic [WORD_SIZE-1:0]          out_data;
  logic                          busy;

  modport master (
    output flush, issue_valid, issue_op, issue_dest, issue_vj, issue_vk,
           issue_qj, issue_qk, cdb_data, cdb_valid, out_ready,
    input  issue_ready, out_valid, out_dest, out_data, busy
  );

  modport slave (
    input  flush, issue_valid, issue_op, issue_dest, issue_vj, issue_vk,
           issue_qj, issue_qk, cdb_data, cdb_valid, out_ready,
    output issue_ready, out_valid, out_dest, out_data, busy
  );
endinterface

// File: rtl/branch_rs_multi.sv
// Multi-entry branch reservation station: CDB operand snooping, oldest-ready-first
// dispatch into a one-deep result register. BRANCH_RS_UNSIGNED_EN enables BLTU/BGEU.
module branch_rs_multi #(
  parameter int                  WORD_SIZE = 32,
  parameter int                  RB_INDEX  = 4,
  parameter int                  RB_SIZE   = 16,
  parameter int                  DEPTH     = 4,
  parameter logic [RB_INDEX-1:0] READY_TAG = {RB_INDEX{1'b1}},
  parameter logic [RB_INDEX-1:0] NULL_TAG  = {RB_INDEX{1'b1}},
  parameter int                  FUINDEX   = 0
) (
  input  logic             clk,
  input  logic             reset,
  branch_rs_multi_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 8 || FUINDEX < 0 || FUINDEX >= RB_SIZE) begin : g_cfg_check
    $error("branch_rs_multi: DEPTH must be 2..8 and FUINDEX a valid result-bus slot");
  end

  logic [DEPTH-1:0]            ent_vld_q, ent_vld_d;
  logic [IDX_W-1:0]            rank_q [DEPTH];
  logic [IDX_W-1:0]            rank_d [DEPTH];
  logic [2:0]                  op_q   [DEPTH];
  logic [2:0]                  op_d   [DEPTH];
  logic [RB_INDEX-1:0]         dest_q [DEPTH];
  logic [RB_INDEX-1:0]         dest_d [DEPTH];
  logic [RB_INDEX-1:0]         qj_q   [DEPTH];
  logic [RB_INDEX-1:0]         qj_d   [DEPTH];
  logic [RB_INDEX-1:0]         qk_q   [DEPTH];
  logic [RB_INDEX-1:0]         qk_d   [DEPTH];
  logic signed [WORD_SIZE-1:0] vj_q   [DEPTH];
  logic signed [WORD_SIZE-1:0] vj_d   [DEPTH];
  logic signed [WORD_SIZE-1:0] vk_q   [DEPTH];
  logic signed [WORD_SIZE-1:0] vk_d   [DEPTH];

  logic                        issue_ready_q, issue_ready_d;
  logic                        res_vld_q, res_vld_d;
  logic [RB_INDEX-1:0]         res_dest_q, res_dest_d;
  logic                        res_taken_q, res_taken_d;

  logic                        sel_found, free_found;
  logic [IDX_W-1:0]            sel_idx, sel_rank, free_idx, new_rank;
  logic                        do_disp, do_issue;

  function automatic logic branch_taken(input logic [2:0] op,
                                        input logic signed [WORD_SIZE-1:0] a,
                                        input logic signed [WORD_SIZE-1:0] b);
    logic taken;
    taken = 1'b0;
    case (op)
      3'd0:    taken = (a == b);
      3'd1:    taken = (a != b);
      3'd2:    taken = (a < b);
      3'd3:    taken = (a >= b);
`ifdef BRANCH_RS_UNSIGNED_EN
      3'd4:    taken = ($unsigned(a) < $unsigned(b));
      3'd5:    taken = ($unsigned(a) >= $unsigned(b));
`endif
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Selection: oldest ready entry (lowest rank) and lowest-index free slot.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_rank   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_q[i] && qj_q[i] == READY_TAG && qk_q[i] == READY_TAG &&
          (!sel_found || rank_q[i] < sel_rank)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = rank_q[i];
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_vld_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    do_disp  = sel_found && (!res_vld_q || bus.out_ready);
    do_issue = bus.issue_valid && issue_ready_q && free_found;
    new_rank = IDX_W'($countones(ent_vld_q) - (do_disp ? 1 : 0));
  end

  always_comb begin
    ent_vld_d   = ent_vld_q;
    rank_d      = rank_q;
    op_d        = op_q;
    dest_d      = dest_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    res_vld_d   = res_vld_q;
    res_dest_d  = res_dest_q;
    res_taken_d = res_taken_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_q[i] && qj_q[i] != READY_TAG && bus.cdb_valid[qj_q[i]]) begin
        vj_d[i] = bus.cdb_data[int'(qj_q[i])*WORD_SIZE +: WORD_SIZE];
        qj_d[i] = READY_TAG;
      end
      if (ent_vld_q[i] && qk_q[i] != READY_TAG && bus.cdb_valid[qk_q[i]]) begin
        vk_d[i] = bus.cdb_data[int'(qk_q[i])*WORD_SIZE +: WORD_SIZE];
        qk_d[i] = READY_TAG;
      end
    end

    if (res_vld_q && bus.out_ready) res_vld_d = 1'b0;

    // Dispatch: evaluate into the result register and close the rank gap.
    if (do_disp) begin
      res_vld_d          = 1'b1;
      res_dest_d         = dest_q[sel_idx];
      res_taken_d        = branch_taken(op_q[sel_idx], vj_q[sel_idx], vk_q[sel_idx]);
      ent_vld_d[sel_idx] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld_q[i] && rank_q[i] > sel_rank) rank_d[i] = rank_q[i] - 1'b1;
      end
    end

    if (do_issue) begin
      ent_vld_d[free_idx] = 1'b1;
      rank_d[free_idx]    = new_rank;
      op_d[free_idx]      = bus.issue_op;
      dest_d[free_idx]    = bus.issue_dest;
      if (bus.issue_qj == READY_TAG) begin
        vj_d[free_idx] = bus.issue_vj;
        qj_d[free_idx] = READY_TAG;
      end else if (bus.cdb_valid[bus.issue_qj]) begin
        vj_d[free_idx] = bus.cdb_data[int'(bus.issue_qj)*WORD_SIZE +: WORD_SIZE];
        qj_d[free_idx] = READY_TAG;
      end else begin
        qj_d[free_idx] = bus.issue_qj;
      end
      if (bus.issue_qk == READY_TAG) begin
        vk_d[free_idx] = bus.issue_vk;
        qk_d[free_idx] = READY_TAG;
      end else if (bus.cdb_valid[bus.issue_qk]) begin
        vk_d[free_idx] = bus.cdb_data[int'(bus.issue_qk)*WORD_SIZE +: WORD_SIZE];
        qk_d[free_idx] = READY_TAG;
      end else begin
        qk_d[free_idx] = bus.issue_qk;
      end
    end

    if (bus.flush) begin
      ent_vld_d = '0;
      res_vld_d = 1'b0;
    end

    issue_ready_d = ($countones(ent_vld_d) < DEPTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_vld_q     <= '0;
      issue_ready_q <= 1'b1;
      res_vld_q     <= 1'b0;
    end else begin
      ent_vld_q     <= ent_vld_d;
      issue_ready_q <= issue_ready_d;
      res_vld_q     <= res_vld_d;
    end
  end

  // Payload registers: only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    rank_q      <= rank_d;
    op_q        <= op_d;
    dest_q      <= dest_d;
    qj_q        <= qj_d;
    qk_q        <= qk_d;
    vj_q        <= vj_d;
    vk_q        <= vk_d;
    res_dest_q  <= res_dest_d;
    res_taken_q <= res_taken_d;
  end

  assign bus.issue_ready = issue_ready_q;
  assign bus.out_valid   = res_vld_q;
  assign bus.out_dest    = res_vld_q ? res_dest_q : NULL_TAG;
  assign bus.out_data    = {{(WORD_SIZE-1){1'b0}}, res_vld_q & res_taken_q};
  assign bus.busy        = (|ent_vld_q) | res_vld_q;

endmodule

// File: tb/tb_branch_rs_multi.sv
// Scoreboard bench for branch_rs_multi: expected results are queued at issue
// time and compared in order as the result handshake completes.
module tb_branch_rs_multi;
  localparam int W = 32;
  localparam int RBI = 4;
  localparam int RBS = 16;
  localparam int DEPTH = 4;
  localparam logic [RBI-1:0] RDY = 4'hF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_rs_multi_if #(.WORD_SIZE(W), .RB_INDEX(RBI), .RB_SIZE(RBS)) bus ();

  branch_rs_multi #(.WORD_SIZE(W), .RB_INDEX(RBI), .RB_SIZE(RBS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [RBI-1:0] dest;
    logic [W-1:0]   data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference compare: signed order via sign-bit flip then unsigned compare.
  function automatic logic [W-1:0] ref_taken(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] fa, fb;
    logic t;
    fa = a ^ 32'h8000_0000;
    fb = b ^ 32'h8000_0000;
    case (op)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd2: t = (fa < fb);
      3'd3: t = !(fa < fb);
`ifdef BRANCH_RS_UNSIGNED_EN
      3'd4: t = (a < b);
      3'd5: t = !(a < b);
`endif
      default: t = 1'b0;
    endcase
    return {31'd0, t};
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("out_dest", 64'(bus.out_dest), 64'(mon_e.dest));
        check("out_data", 64'(bus.out_data), 64'(mon_e.data));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.issue_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_ready_wait", 64'(bus.issue_ready), 64'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [RBI-1:0] dest, input logic [W-1:0] vj,
                       input logic [W-1:0] vk, input logic [RBI-1:0] qj, input logic [RBI-1:0] qk);
    wait_ready();
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_dest  = dest;
    bus.issue_vj    = vj;
    bus.issue_vk    = vk;
    bus.issue_qj    = qj;
    bus.issue_qk    = qk;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
  endtask

  task automatic issue_push(input logic [2:0] op, input logic [RBI-1:0] dest,
                            input logic [W-1:0] vj, input logic [W-1:0] vk);
    sb.push_back('{dest: dest, data: ref_taken(op, vj, vk)});
    issue(op, dest, vj, vk, RDY, RDY);
  endtask

  task automatic cdb_pulse(input int tag, input logic [W-1:0] data);
    bus.cdb_valid[tag] = 1'b1;
    bus.cdb_data[tag*W +: W] = data;
    @(posedge clk); #1;
    bus.cdb_valid = '0;
  endtask

  task automatic wait_sb_empty();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_idle", 64'(sb.size() == 0 && !bus.busy), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] tops [8] = '{3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd6, 3'd7, 3'd3};
    logic [W-1:0] ta [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd1, 32'd3, 32'hFFFF_FFFF};
    logic [W-1:0] tb [8] = '{32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'd2, 32'd3, 32'd1};
    logic [2:0] fops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [W-1:0] fvk [4] = '{32'd7, 32'd7, 32'd9, 32'd9};

    reset = 1'b1;
    bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_dest = '0;
    bus.issue_vj = '0; bus.issue_vk = '0; bus.issue_qj = RDY; bus.issue_qk = RDY;
    bus.cdb_data = '0; bus.cdb_valid = '0; bus.out_ready = 1'b1;
    #1;
    check("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_dest", 64'(bus.out_dest), 64'hF);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Minimum latency BGE
    issue_push(3'd3, 4'd5, 32'd5, 32'd3);
    check("lat_edge_n", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_edge_n1", 64'(bus.out_valid), 64'd1);
    check("lat_dest", 64'(bus.out_dest), 64'd5);
    drain();
    check("busy_idle", 64'(bus.busy), 64'd0);

    // Compare-mode table, back to back
    for (int i = 0; i < 8; i++) issue_push(tops[i], RBI'(i), ta[i], tb[i]);
    drain();

    // Random compares
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] a, b;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      issue_push(3'($urandom_range(0, 7)), RBI'($urandom_range(0, 14)), a, b);
    end
    drain();

    // Fill all entries waiting on tag 3, then release
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back('{dest: RBI'(8 + i), data: ref_taken(fops[i], 32'd7, fvk[i])});
      issue(fops[i], RBI'(8 + i), 32'd0, fvk[i], 4'd3, RDY);
    end
    check("full_ready", 64'(bus.issue_ready), 64'd0);
    cdb_pulse(3, 32'd7);
    check("full_after_snoop", 64'(bus.issue_ready), 64'd0);
    @(posedge clk); #1;
    check("ready_after_free", 64'(bus.issue_ready), 64'd1);
    drain();

    // Age order differs from slot order after a slot is reused
    issue(3'd0, 4'd1, 32'd0, 32'd7, 4'd4, RDY);
    issue(3'd1, 4'd2, 32'd0, 32'd0, 4'd5, RDY);
    issue(3'd3, 4'd3, 32'd0, 32'd100, 4'd4, RDY);
    sb.push_back('{dest: 4'd2, data: ref_taken(3'd1, 32'd1, 32'd0)});
    cdb_pulse(5, 32'd1);
    wait_sb_empty();
    issue(3'd2, 4'd4, 32'd0, 32'hFFFF_FFFB, 4'd4, RDY);
    sb.push_back('{dest: 4'd1, data: ref_taken(3'd0, 32'd7, 32'd7)});
    sb.push_back('{dest: 4'd3, data: ref_taken(3'd3, 32'd7, 32'd100)});
    sb.push_back('{dest: 4'd4, data: ref_taken(3'd2, 32'd7, 32'hFFFF_FFFB)});
    cdb_pulse(4, 32'd7);
    drain();

    // Operand captured from the CDB in the issue cycle
    bus.cdb_valid[6] = 1'b1;
    bus.cdb_data[6*W +: W] = 32'hFFFF_FFFD;
    sb.push_back('{dest: 4'd7, data: ref_taken(3'd2, 32'hFFFF_FFFD, 32'd2)});
    issue(3'd2, 4'd7, 32'd0, 32'd2, 4'd6, RDY);
    bus.cdb_valid = '0;
    drain();

    // Back-pressure
    bus.out_ready = 1'b0;
    issue_push(3'd0, 4'd9, 32'd1, 32'd1);
    issue_push(3'd1, 4'd10, 32'd1, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", 64'(bus.out_valid), 64'd1);
    check("hold_dest", 64'(bus.out_dest), 64'd9);
    repeat (2) @(posedge clk);
    #1;
    check("hold_dest_stable", 64'(bus.out_dest), 64'd9);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 64'(bus.out_valid), 64'd1);
    check("release_dest", 64'(bus.out_dest), 64'd10);
    drain();

    // Flush with three entries plus a held result
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(3'd0, RBI'(11 + i), 32'd0, 32'd0, RDY, RDY);
    check("pre_flush_valid", 64'(bus.out_valid), 64'd1);
    check("pre_flush_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_ready", 64'(bus.issue_ready), 64'd1);
    @(posedge clk); #1;
    check("flush_stays_empty", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) issue(3'd0, RBI'(11 + i), 32'd0, 32'd0, RDY, RDY);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("areset_valid", 64'(bus.out_valid), 64'd0);
    check("areset_busy", 64'(bus.busy), 64'd0);
    check("areset_ready", 64'(bus.issue_ready), 64'd1);
    check("areset_dest", 64'(bus.out_dest), 64'hF);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // Unsigned modes after recovery
    issue_push(3'd5, 4'd6, 32'hFFFF_FFFF, 32'd1);
    issue_push(3'd4, 4'd2, 32'd1, 32'hFFFF_FFFF);
    drain();
    check("sb_left", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
